input_packet_buffer: RTL and testbench
======================================

INPUT_PACKET_BUFFER -- requirements
Module: input_packet_buffer

Interface
REQ-001 SHALL have parameter PACKET_WIDTH, default 30, width of one routed spike packet (dx 9 + dy 9 + axon 8 + tick 4).
REQ-002 SHALL have parameter DEPTH, default 16, number of packet entries; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port wr_data, input, PACKET_WIDTH, packet from the host or loader.
REQ-006 SHALL have port wr_valid, input, 1, wr_data is valid this cycle.
REQ-007 SHALL have port wr_ready, output, 1, buffer accepts a write this cycle.
REQ-008 SHALL have port packet_out, output, PACKET_WIDTH, head packet; drives the grid packet_in.
REQ-009 SHALL have port empty, output, 1, no packet held; drives the grid input_buffer_empty.
REQ-010 SHALL have port ren, input, 1, pop request; driven by the grid ren_to_input_buffer.
REQ-011 SHALL have port count, output, $clog2(DEPTH)+1, current number of held packets.
REQ-012 SHALL have port underflow_error, output, 1, sticky flag for a pop while empty.

Function
REQ-013 SHALL be first-word-fall-through: when empty=0, packet_out equals the oldest held packet with no read latency.
REQ-014 SHALL accept a write when wr_valid=1 and wr_ready=1; the packet is stored at the write pointer, and the write pointer advances modulo DEPTH.
REQ-015 SHALL drive wr_ready = (count != DEPTH), combinational from registered count; no same-cycle bypass when full, even if ren=1.
REQ-016 SHALL pop when ren=1 and empty=0; the read pointer advances modulo DEPTH and packet_out shows the next entry in the following cycle.
REQ-017 SHALL derive empty = (count == 0); a write into an empty buffer deasserts empty one cycle later (write-to-visible latency 1; no write-to-read bypass).
REQ-018 SHALL, on a simultaneous accepted write and pop, leave count unchanged and advance both pointers.
REQ-019 SHALL update count as +1 for write only, -1 for pop only, and 0 for both or neither; count never exceeds DEPTH and never goes below 0.
REQ-020 SHALL ignore ren when empty=1: pointers and count are unchanged and underflow_error is set to 1 until reset.
REQ-021 SHALL preserve FIFO order across pointer wrap-around with no packet loss or duplication.
REQ-022 SHALL drive packet_out with an unspecified value when empty=1; consumers must not sample it then.

Reset
REQ-023 SHALL, while rst=1, clear both pointers, count=0, empty=1, wr_ready=1 and underflow_error=0; storage contents need not be cleared.
REQ-024 SHALL give rst priority over same-cycle wr_valid and ren; a reset mid-stream discards all held packets, and no write is accepted in that cycle.

Structure
REQ-025 SHALL take the packet field widths (DX, DY, axon and tick widths) from the shared SpikeHard package used by the grid; PACKET_WIDTH at instantiation equals the grid PACKET_WIDTH.
REQ-026 SHALL be implemented as one module with a register-array memory (asynchronous read) plus a pointer/count control block; no sub-module.

Verification
REQ-027 SHALL cover single packet: reset, then write 0x0000_0A5 with ren=0 -> empty=0 next cycle, packet_out=0x0A5, count=1; then ren=1 for one cycle -> empty=1, count=0.
REQ-028 SHALL cover fill to full: 16 consecutive writes of values 1..16 with ren=0 -> count=16, wr_ready=0; a 17th wr_valid is not accepted; then 16 pops return 1..16 in order.
REQ-029 SHALL cover simultaneous operation: with count=5, wr_valid=1 and ren=1 for 20 cycles -> count stays 5 throughout, output order is preserved, and the pointers wrap.
REQ-030 SHALL cover full plus ren: with count=16, wr_valid=1 and ren=1 -> the write is rejected and count=15 next cycle; the write is accepted on the following cycle.
REQ-031 SHALL cover underflow: ren=1 while empty -> underflow_error=1 and count=0; the flag stays high after later writes and clears only on rst.
REQ-032 SHALL cover reset mid-operation: with count=7, assert rst together with wr_valid=1 -> count=0, empty=1 next cycle, and the written packet is never seen.

Source files
------------

// File: rtl/input_packet_buffer_pkg.sv
// Shared spike-packet field widths and buffer operation encoding.
package input_packet_buffer_pkg;

  localparam int DX_WIDTH   = 9;
  localparam int DY_WIDTH   = 9;
  localparam int AXON_WIDTH = 8;
  localparam int TICK_WIDTH = 4;
  localparam int PKT_WIDTH  = DX_WIDTH + DY_WIDTH + AXON_WIDTH + TICK_WIDTH;

  // {push, pop} as seen by the count update
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

endpackage

// File: rtl/input_packet_buffer.sv
// First-word-fall-through packet FIFO feeding the grid packet input.
module input_packet_buffer
  import input_packet_buffer_pkg::*;
#(
  parameter int PACKET_WIDTH = PKT_WIDTH,
  parameter int DEPTH        = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PACKET_WIDTH-1:0]   wr_data,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  output logic [PACKET_WIDTH-1:0]   packet_out,
  output logic                      empty,
  input  logic                      ren,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      underflow_error
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [PACKET_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [AW:0]             count_q;
  logic                    wr_en;
  logic                    rd_en;
  op_e                     op;

  assign wr_ready   = (count_q != FULL);
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign packet_out = mem[rd_ptr];

  // Both qualifiers use registered count, so a full buffer never bypasses on a pop
  assign wr_en = wr_valid && wr_ready;
  assign rd_en = ren && !empty;
  assign op    = op_e'({wr_en, rd_en});

  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count_q         <= '0;
      underflow_error <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (ren && empty) begin
        underflow_error <= 1'b1;
      end
      case (op)
        OP_PUSH: count_q <= count_q + 1'b1;
        OP_POP:  count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_input_packet_buffer.sv
// Directed bench for input_packet_buffer with a queue-based scoreboard.
module tb_input_packet_buffer;

  localparam int PW = 30;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [PW-1:0] packet_out;
  logic          empty;
  logic          ren;
  logic [4:0]    count;
  logic          underflow_error;

  int            checks   = 0;
  int            failures = 0;
  logic [PW-1:0] sb[$];
  logic          uf_exp = 1'b0;

  always #5 clk = ~clk;

  input_packet_buffer #(.PACKET_WIDTH(PW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .packet_out(packet_out), .empty(empty),
    .ren(ren), .count(count), .underflow_error(underflow_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ":count"}, 32'(count), 32'(sb.size()));
    chk({tag, ":empty"}, 32'(empty), 32'(sb.size() == 0));
    chk({tag, ":wr_ready"}, 32'(wr_ready), 32'(sb.size() != D));
    chk({tag, ":underflow"}, 32'(underflow_error), 32'(uf_exp));
    if (sb.size() != 0) chk({tag, ":head"}, 32'(packet_out), 32'(sb[0]));
  endtask

  // Drives one cycle of inputs; scoreboard decides acceptance from its own occupancy.
  task automatic cycle(input string tag, input logic r, input logic wv,
                       input logic [PW-1:0] wd, input logic rn);
    logic push;
    logic pop;
    rst = r; wr_valid = wv; wr_data = wd; ren = rn;
    #1;
    push = wv && (sb.size() < D);
    pop  = rn && (sb.size() > 0);
    if (r) begin
      sb.delete();
      uf_exp = 1'b0;
    end else begin
      if (pop) chk({tag, ":pop_data"}, 32'(packet_out), 32'(sb.pop_front()));
      if (rn && !pop) uf_exp = 1'b1;
      if (push) sb.push_back(wd);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; wr_valid = 1'b0; ren = 1'b0;
    check_state(tag);
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; ren = 1'b0;
    @(posedge clk); #1;
    cycle("reset", 1'b1, 1'b0, '0, 1'b0);

    // single packet
    cycle("single_wr", 1'b0, 1'b1, 30'h0A5, 1'b0);
    chk("single_head", 32'(packet_out), 32'h0A5);
    cycle("single_rd", 1'b0, 1'b0, '0, 1'b1);

    // fill to full, reject 17th, drain in order
    for (int i = 1; i <= 16; i++) cycle("fill", 1'b0, 1'b1, PW'(i), 1'b0);
    chk("full_wr_ready", 32'(wr_ready), 32'd0);
    cycle("17th", 1'b0, 1'b1, PW'(17), 1'b0);
    for (int i = 0; i < 16; i++) cycle("drain", 1'b0, 1'b0, '0, 1'b1);

    // simultaneous push/pop at count=5, pointers wrap
    for (int i = 0; i < 5; i++) cycle("pre5", 1'b0, 1'b1, PW'(100 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle("both", 1'b0, 1'b1, PW'(200 + i), 1'b1);
      chk("both_count5", 32'(count), 32'd5);
    end
    for (int i = 0; i < 5; i++) cycle("drain5", 1'b0, 1'b0, '0, 1'b1);

    // full plus ren: write rejected, then accepted next cycle
    for (int i = 0; i < 16; i++) cycle("fill2", 1'b0, 1'b1, PW'(300 + i), 1'b0);
    cycle("full_ren", 1'b0, 1'b1, 30'h3E7, 1'b1);
    chk("full_ren_count", 32'(count), 32'd15);
    cycle("refill", 1'b0, 1'b1, 30'h3E7, 1'b0);
    chk("refill_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) cycle("drain2", 1'b0, 1'b0, '0, 1'b1);

    // underflow is sticky until reset
    cycle("underflow", 1'b0, 1'b0, '0, 1'b1);
    chk("uf_set", 32'(underflow_error), 32'd1);
    cycle("uf_wr", 1'b0, 1'b1, 30'h55, 1'b0);
    cycle("uf_rd", 1'b0, 1'b0, '0, 1'b1);
    chk("uf_sticky", 32'(underflow_error), 32'd1);

    // reset mid-stream discards everything including the same-cycle write
    for (int i = 0; i < 7; i++) cycle("pre7", 1'b0, 1'b1, PW'(400 + i), 1'b0);
    cycle("mid_rst", 1'b1, 1'b1, 30'h3FFF_FFFF, 1'b0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    cycle("post_wr", 1'b0, 1'b1, 30'h42, 1'b0);
    chk("post_head", 32'(packet_out), 32'h42);
    cycle("post_rd", 1'b0, 1'b0, '0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
